// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV32I opcodes and pipeline record kinds shared by the issue controller.
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_EQ   = 4'b0010;
    localparam logic [3:0] ALU_NEQ  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_ADDC = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1111;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [2:0] {K_ALU, K_BRANCH, K_JAL, K_JALR, K_ILLEGAL} kind_e;

    // funct3 to control code for OP/OP-IMM; alt selects SUB/SRA
    function automatic logic [3:0] f3_ctrl(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_ctrl = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_ctrl = ALU_SLL;
            3'b010:  f3_ctrl = ALU_SLT;
            3'b011:  f3_ctrl = ALU_SLTU;
            3'b100:  f3_ctrl = ALU_XOR;
            3'b101:  f3_ctrl = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_ctrl = ALU_OR;
            default: f3_ctrl = ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate of the format implied by the opcode (I/S/B/U/J).
module imm_gen
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);
    logic [6:0] w_op;
    assign w_op = i_instr[6:0];
    always_comb begin
        o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
        if (w_op == OP_STORE)
            o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        else if (w_op == OP_BRANCH)
            o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        else if (w_op == OP_LUI || w_op == OP_AUIPC)
            o_imm = {i_instr[31:12], 12'b0};
        else if (w_op == OP_JAL)
            o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes RV32I into ALU control/operands (E stage) and turns the ALU
// result into a writeback / branch-resolution record (W stage).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [3:0]      o_alu_ctrl,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [3:0]      i_alu_flags,
    output logic            o_wb_valid,
    input  logic            i_wb_ready,
    output logic            o_wb_we,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_br_taken,
    output logic [XLEN-1:0] o_br_target,
    output logic            o_illegal
);
    logic [6:0]      w_op, w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rd;
    logic [31:0]     w_imm;
    logic [XLEN-1:0] w_a, w_b;
    logic [3:0]      w_ctrl;
    kind_e           w_kind;
    logic            w_inv, w_we, w_w_adv, w_accept, w_e_jump;

    logic            r_e_valid, r_e_we, r_e_inv;
    logic [XLEN-1:0] r_e_a, r_e_b, r_e_target, r_e_link;
    logic [3:0]      r_e_ctrl;
    logic [4:0]      r_e_rd;
    kind_e           r_e_kind;

    logic            r_w_valid, r_w_we, r_w_taken, r_w_illegal;
    logic [4:0]      r_w_rd;
    logic [XLEN-1:0] r_w_data, r_w_target;

    assign w_op = i_instr[6:0];
    assign w_rd = i_instr[11:7];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];

    imm_gen u_imm_gen (.i_instr(i_instr), .o_imm(w_imm));

    always_comb begin
        w_a    = i_rs1_data;
        w_b    = i_rs2_data;
        w_ctrl = ALU_ADD;
        w_kind = K_ILLEGAL;
        w_inv  = 1'b0;
        case (w_op)
            OP_OP: if (w_f7 == 7'b0 || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                w_ctrl = f3_ctrl(w_f3, w_f7[5]);
                w_kind = K_ALU;
            end
            OP_IMM: begin
                w_b = (w_f3[1:0] == 2'b01) ? XLEN'(i_instr[24:20]) : w_imm;
                if ((w_f3 != 3'b001 || w_f7 == 7'b0) &&
                    (w_f3 != 3'b101 || w_f7 == 7'b0 || w_f7 == F7_ALT)) begin
                    w_ctrl = f3_ctrl(w_f3, w_f3 == 3'b101 && w_f7[5]);
                    w_kind = K_ALU;
                end
            end
            OP_LUI: begin
                w_a    = '0;
                w_b    = w_imm;
                w_kind = K_ALU;
            end
            OP_AUIPC: begin
                w_a    = i_pc;
                w_b    = w_imm;
                w_kind = K_ALU;
            end
            // BLT/BGE share SLT, BLTU/BGEU share SLTU; the >= forms invert bit 0
            OP_BRANCH: if (w_f3[2:1] != 2'b01) begin
                w_ctrl = w_f3[2] ? (w_f3[1] ? ALU_SLTU : ALU_SLT) : (w_f3[0] ? ALU_NEQ : ALU_EQ);
                w_inv  = w_f3[2] & w_f3[0];
                w_kind = K_BRANCH;
            end
            OP_JAL: begin
                w_a    = i_pc;
                w_b    = XLEN'(4);
                w_kind = K_JAL;
            end
            OP_JALR: if (w_f3 == 3'b000) begin
                w_b    = w_imm;
                w_ctrl = ALU_ADDC;
                w_kind = K_JALR;
            end
            default: ;
        endcase
    end

    assign w_we       = (w_rd != 5'd0) && (w_kind == K_ALU || w_kind == K_JAL || w_kind == K_JALR);
    assign w_w_adv    = !r_w_valid || i_wb_ready;
    assign o_in_ready = !r_e_valid || w_w_adv;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_e_jump   = r_e_kind == K_JAL || r_e_kind == K_JALR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_valid   <= 1'b0;
            r_e_we      <= 1'b0;
            r_e_inv     <= 1'b0;
            r_e_a       <= '0;
            r_e_b       <= '0;
            r_e_target  <= '0;
            r_e_link    <= '0;
            r_e_ctrl    <= ALU_ADD;
            r_e_rd      <= '0;
            r_e_kind    <= K_ALU;
            r_w_valid   <= 1'b0;
            r_w_we      <= 1'b0;
            r_w_taken   <= 1'b0;
            r_w_illegal <= 1'b0;
            r_w_rd      <= '0;
            r_w_data    <= '0;
            r_w_target  <= '0;
        end else begin
            if (o_in_ready)
                r_e_valid <= i_in_valid;
            if (w_accept) begin
                r_e_we     <= w_we;
                r_e_inv    <= w_inv;
                r_e_a      <= w_a;
                r_e_b      <= w_b;
                r_e_target <= i_pc + w_imm;
                r_e_link   <= i_pc + XLEN'(4);
                r_e_ctrl   <= w_ctrl;
                r_e_rd     <= w_rd;
                r_e_kind   <= w_kind;
            end
            if (w_w_adv)
                r_w_valid <= r_e_valid;
            if (w_w_adv && r_e_valid) begin
                r_w_we      <= r_e_we;
                r_w_rd      <= r_e_rd;
                r_w_illegal <= r_e_kind == K_ILLEGAL;
                r_w_data    <= w_e_jump ? r_e_link : i_alu_result;
                r_w_taken   <= (r_e_kind == K_BRANCH) ? i_alu_result[0] ^ r_e_inv : w_e_jump;
                r_w_target  <= (r_e_kind == K_JALR) ? i_alu_result :
                               (r_e_kind == K_BRANCH || r_e_kind == K_JAL) ? r_e_target : '0;
            end
        end
    end

    // flags are not used for decisions, only sanity-checked against the result
    assert property (@(posedge clk) disable iff (rst)
        r_e_valid |-> (!$isunknown(i_alu_flags) && !i_alu_flags[2] && i_alu_flags[0] == (i_alu_result == '0)));

    assign o_alu_a     = r_e_a;
    assign o_alu_b     = r_e_b;
    assign o_alu_ctrl  = r_e_ctrl;
    assign o_wb_valid  = r_w_valid;
    assign o_wb_we     = r_w_we;
    assign o_wb_rd     = r_w_rd;
    assign o_wb_data   = r_w_data;
    assign o_br_taken  = r_w_taken;
    assign o_br_target = r_w_target;
    assign o_illegal   = r_w_illegal;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: random + directed RV32I stream against an ISA-level reference model,
// with a behavioural ALU closing the loop and a queue-based writeback scoreboard.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl, alu_flags;
    logic        wb_valid, wb_ready, wb_we, br_taken, illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, br_target;
    logic [32:0] sum;
    int          checks = 0, errors = 0, hold_lo = 0;
    logic        rnd_rdy = 1'b0;

    typedef struct {
        logic        ill, we, br, taken, chk_data;
        logic [4:0]  rd;
        logic [31:0] data, target;
        logic [3:0]  ctrl;
    } exp_t;
    exp_t exp_q[$];

    alu_issue_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_instr(instr),
        .i_pc(pc), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .o_alu_ctrl(alu_ctrl), .i_alu_result(alu_result), .i_alu_flags(alu_flags),
        .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_we(wb_we), .o_wb_rd(wb_rd),
        .o_wb_data(wb_data), .o_br_taken(br_taken), .o_br_target(br_target), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    // behavioural ALU implementing the control-code table
    assign sum = {1'b0, alu_a} + {1'b0, alu_b};
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = {31'b0, alu_a == alu_b};
            4'b0011: alu_result = {31'b0, alu_a != alu_b};
            4'b0100: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            4'b0110: alu_result = (alu_a + alu_b) & ~32'd1;
            4'b0111: alu_result = alu_a ^ alu_b;
            4'b1000: alu_result = alu_a << alu_b[4:0];
            4'b1001: alu_result = alu_a >> alu_b[4:0];
            4'b1010: alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'b1100: alu_result = {31'b0, alu_a < alu_b};
            4'b1111: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
        alu_flags = {sum[32], 1'b0, alu_result[31], alu_result == 32'd0};
    end

    function automatic logic [35:0] ref_op(input logic [2:0] f3, input logic alt, input logic [31:0] x, y);
        case (f3)
            3'd0:    return alt ? {4'h1, x - y} : {4'h0, x + y};
            3'd1:    return {4'h8, x << y[4:0]};
            3'd2:    return {4'hF, 31'b0, $signed(x) < $signed(y)};
            3'd3:    return {4'hC, 31'b0, x < y};
            3'd4:    return {4'h7, x ^ y};
            3'd5:    return alt ? {4'hA, 32'($signed(x) >>> y[4:0])} : {4'h9, x >> y[4:0]};
            3'd6:    return {4'h5, x | y};
            default: return {4'h4, x & y};
        endcase
    endfunction

    // RV32I semantics of one instruction, independent of any pipelining
    function automatic exp_t model(input logic [31:0] ins, p, x, y);
        exp_t e;
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [31:0] imm_u = {ins[31:12], 12'b0};
        logic [31:0] imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        logic [35:0] r;
        e = '{ill: 1'b1, we: 1'b0, br: 1'b0, taken: 1'b0, chk_data: 1'b0, rd: ins[11:7],
              data: '0, target: '0, ctrl: 4'h0};
        case (ins[6:0])
            7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                r = ref_op(f3, f7[5], x, y);
                {e.ctrl, e.data} = r;
                e.ill = 1'b0;
            end
            7'b0010011: if (!((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) begin
                r = ref_op(f3, f3 == 3'd5 && f7[5], x, (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, ins[24:20]} : imm_i);
                {e.ctrl, e.data} = r;
                e.ill = 1'b0;
            end
            7'b0110111: begin e.ill = 1'b0; e.data = imm_u; end
            7'b0010111: begin e.ill = 1'b0; e.data = p + imm_u; end
            7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) begin
                e.ill = 1'b0; e.br = 1'b1; e.target = p + imm_b;
                case (f3)
                    3'd0:    begin e.taken = x == y;                   e.ctrl = 4'h2; end
                    3'd1:    begin e.taken = x != y;                   e.ctrl = 4'h3; end
                    3'd4:    begin e.taken = $signed(x) < $signed(y);  e.ctrl = 4'hF; end
                    3'd5:    begin e.taken = $signed(x) >= $signed(y); e.ctrl = 4'hF; end
                    3'd6:    begin e.taken = x < y;                    e.ctrl = 4'hC; end
                    default: begin e.taken = x >= y;                   e.ctrl = 4'hC; end
                endcase
            end
            7'b1101111: begin e.ill = 1'b0; e.br = 1'b1; e.taken = 1'b1; e.data = p + 4; e.target = p + imm_j; end
            7'b1100111: if (f3 == 3'd0) begin
                e.ill = 1'b0; e.br = 1'b1; e.taken = 1'b1; e.data = p + 4;
                e.target = (x + imm_i) & ~32'd1; e.ctrl = 4'h6;
            end
            default: ;
        endcase
        e.chk_data = !e.ill && ins[6:0] != 7'b1100011;
        e.we = e.chk_data && e.rd != 5'd0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard/monitor: pushes on accept, pops and compares on retire
    initial begin
        exp_t e, g;
        logic       pend = 1'b0;
        logic [3:0] pend_ctrl = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pend = 1'b0;
            end else begin
                if (pend) chk("e_alu_ctrl", 32'(alu_ctrl), 32'(pend_ctrl));
                pend = 1'b0;
                chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2 || wb_ready));
                if (wb_valid && exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_wb: wb_valid=1 with nothing in flight (t=%0t)", $time);
                end else if (wb_valid && wb_ready) begin
                    g = exp_q.pop_front();
                    chk("wb_we", 32'(wb_we), 32'(g.we));
                    chk("illegal", 32'(illegal), 32'(g.ill));
                    chk("br_taken", 32'(br_taken), 32'(g.taken));
                    if (g.we) chk("wb_rd", 32'(wb_rd), 32'(g.rd));
                    if (g.chk_data) chk("wb_data", wb_data, g.data);
                    if (g.br) chk("br_target", br_target, g.target);
                end
                if (in_valid && in_ready) begin
                    e = model(instr, pc, rs1_data, rs2_data);
                    exp_q.push_back(e);
                    pend = !e.ill;
                    pend_ctrl = e.ctrl;
                end
            end
        end
    end

    initial begin
        wb_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold_lo > 0) begin
                wb_ready = 1'b0;
                hold_lo--;
            end else wb_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic offer(input logic [31:0] ins, p, r1, r2);
        in_valid = 1'b1; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n == 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready=0 expected 1 within 50 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d records outstanding expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset();
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_br_taken", 32'(br_taken), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_br_target", br_target, 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    initial begin
        logic [31:0] r, ins, a1, a2;
        logic [6:0]  f7;
        repeat (3) @(posedge clk);
        #2;
        chk_reset();
        rst = 1'b0;
        offer(enc_i(12'hFFF, 5'd0, 3'd0, 5'd5, 7'b0010011), 32'h0, 32'h0, 32'h0);
        offer(enc_i({7'h20, 5'd4}, 5'd2, 3'd5, 5'd1, 7'b0010011), 32'h4, 32'h8000_0000, 32'h0);
        offer({7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 32'h8, 32'd10, 32'd3);
        offer(enc_b(13'd16, 5'd2, 5'd1, 3'd7), 32'h100, 32'd1, 32'd2);
        offer(enc_b(13'd16, 5'd2, 5'd1, 3'd7), 32'h100, 32'd3, 32'd2);
        offer(enc_i(12'd4, 5'd6, 3'd0, 5'd1, 7'b1100111), 32'h200, 32'h1001, 32'h0);
        offer({20'h00010, 5'd7, 7'b1101111}, 32'h300, 32'h0, 32'h0);
        offer({20'hABCDE, 5'd8, 7'b0110111}, 32'h304, 32'h0, 32'h0);
        offer({20'h00001, 5'd0, 7'b0010111}, 32'h308, 32'h0, 32'h0);
        offer(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h400, 32'h55, 32'h55);
        offer(32'h0000_2083, 32'h404, 32'h1, 32'h2);
        drain();
        #2;
        hold_lo = 4;
        @(posedge clk); #1;
        offer({7'h00, 5'd2, 5'd1, 3'd0, 5'd9, 7'b0110011}, 32'h500, 32'd7, 32'd8);
        offer({7'h00, 5'd2, 5'd1, 3'd4, 5'd10, 7'b0110011}, 32'h504, 32'hF0F0, 32'h0FF0);
        offer(32'h0000_0583, 32'h508, 32'h1, 32'h2);
        offer(enc_i(12'h800, 5'd1, 3'd2, 5'd11, 7'b0010011), 32'h50C, 32'h0, 32'h0);
        drain();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r  = $urandom;
            f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
            case ($urandom_range(0, 7))
                0: ins = {f7, r[24:7], 7'b0110011};
                1: ins = {f7, r[24:7], 7'b0010011};
                2: ins = {r[31:7], 7'b0110111};
                3: ins = {r[31:7], 7'b0010111};
                4: ins = {r[31:7], 7'b1100011};
                5: ins = {r[31:7], 7'b1101111};
                6: ins = {r[31:15], ($urandom_range(0, 3) == 0) ? r[14:12] : 3'b000, r[11:7], 7'b1100111};
                default: ins = {r[31:7], ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'b1110011};
            endcase
            a1 = $urandom;
            a2 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            offer(ins, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, a1, a2);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if (i == 150) begin
                rst = 1'b1;
                @(posedge clk); #2;
                chk_reset();
                rst = 1'b0;
            end
        end
        drain();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
